// File: rtl/kgp_risc_pkg.sv
// Shared branch-label definitions: widths, types and the label fit rule used by
// both the label encoder and the sign-extension side of the branch datapath.
package kgp_risc_pkg;

    localparam int WORD_W  = 32;
    localparam int LABEL_W = 24;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [LABEL_W-1:0] label_t;

    // A byte offset fits a signed label when every bit from the label sign bit upward agrees.
    function automatic logic label_fits(input word_t diff);
        logic [WORD_W-LABEL_W:0] hi;
        hi = diff[WORD_W-1:LABEL_W-1];
        return (hi == {(WORD_W-LABEL_W+1){1'b0}}) || (hi == {(WORD_W-LABEL_W+1){1'b1}});
    endfunction

    function automatic word_t sext_label(input label_t lbl);
        return {{(WORD_W-LABEL_W){lbl[LABEL_W-1]}}, lbl};
    endfunction

endpackage

// File: rtl/label_range_check.sv
// Combinational split of a 32-bit byte offset into its 24-bit label and a
// flag saying the label cannot represent the offset.
module label_range_check
    import kgp_risc_pkg::*;
(
    input  word_t  diff,
    output label_t label,
    output logic   ovf
);

    assign label = diff[LABEL_W-1:0];
    assign ovf   = !label_fits(diff);

endmodule

// File: rtl/label_encoder.sv
// Two-stage valid/ready pipeline turning absolute branch targets into
// PC-relative labels, with a sticky overflow flag and saturating counter.
module label_encoder
    import kgp_risc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WORD_W-1:0]  target,
    input  logic [WORD_W-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LABEL_W-1:0] label,
    output logic             ovf,
    output logic             err,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             clr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       s1_valid_q, s1_valid_d;
    word_t      s1_diff_q,  s1_diff_d;
    logic       s2_valid_q, s2_valid_d;
    label_t     label_q,    label_d;
    logic       ovf_q,      ovf_d;
    logic       err_q,      err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       adv1, adv2, out_hs;
    label_t     rc_label;
    logic       rc_ovf;

    label_range_check u_range_check (
        .diff  (s1_diff_q),
        .label (rc_label),
        .ovf   (rc_ovf)
    );

    assign adv2   = !s2_valid_q || out_ready;
    assign adv1   = !s1_valid_q || adv2;
    assign out_hs = s2_valid_q && out_ready;

    // Reset forces in_ready high so the upstream never sees a stall while the pipe is being flushed.
    assign in_ready  = adv1 || rst;
    assign out_valid = s2_valid_q;
    assign label     = label_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign ovf_cnt   = cnt_q;

    // Next-state for both pipeline stages and the overflow bookkeeping.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_diff_d  = s1_diff_q;
        s2_valid_d = s2_valid_q;
        label_d    = label_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_diff_d = target - pc;
            end else begin
                s1_diff_d = s1_diff_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                label_d = rc_label;
                ovf_d   = rc_ovf;
            end else begin
                label_d = label_q;
                ovf_d   = ovf_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        // Clear first, then count, so a coincident overflowed handoff still registers.
        if (clr_err) begin
            err_d = 1'b0;
            cnt_d = {CNT_W{1'b0}};
        end else begin
            err_d = err_q;
            cnt_d = cnt_q;
        end

        if (out_hs && ovf_q) begin
            err_d = 1'b1;
            if (cnt_d == CNT_MAX) begin
                cnt_d = CNT_MAX;
            end else begin
                cnt_d = cnt_d + CNT_ONE;
            end
        end else begin
            err_d = err_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_diff_q  <= {WORD_W{1'b0}};
            s2_valid_q <= 1'b0;
            label_q    <= {LABEL_W{1'b0}};
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s2_valid_q <= s2_valid_d;
            label_q    <= label_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_label_encoder.sv
// Self-checking bench for label_encoder: an in-order queue model of accepted
// items predicts every output each cycle, plus directed literal checks.
module tb_label_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] target;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] label;
    logic        ovf;
    logic        err;
    logic [7:0]  ovf_cnt;
    logic        clr_err;

    label_encoder #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .target    (target),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .label     (label),
        .ovf       (ovf),
        .err       (err),
        .ovf_cnt   (ovf_cnt),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] lab;
        logic        ovf;
        int          acc;
    } item_t;

    item_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    bit    armed = 1'b0;
    bit    m_err = 1'b0;
    int    m_cnt = 0;
    bit    last_in_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic cycle();
        bit exp_ir, exp_ov, in_hs, out_hs, do_rst, do_clr;
        int d;
        item_t it;
        #1;
        exp_ir = rst || (q.size() < 2) || out_ready;
        exp_ov = (q.size() != 0) && (cyc >= q[0].acc + 2);
        if (armed) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_ov) begin
                chk("label", {8'd0, label}, {8'd0, q[0].lab});
                chk("ovf", {31'd0, ovf}, {31'd0, q[0].ovf});
            end
            chk("err", {31'd0, err}, {31'd0, m_err});
            chk("ovf_cnt", {24'd0, ovf_cnt}, m_cnt);
        end
        in_hs  = in_valid && exp_ir && !rst;
        out_hs = exp_ov && out_ready;
        do_rst = rst;
        do_clr = clr_err;
        d = target - pc;
        it.lab = d[23:0];
        it.ovf = (d > 8388607) || (d < -8388608);
        it.acc = cyc;
        @(posedge clk);
        last_in_hs = in_hs;
        if (do_rst) begin
            q.delete();
            m_err = 1'b0;
            m_cnt = 0;
            armed = 1'b1;
        end else begin
            if (do_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
            if (out_hs) begin
                if (q[0].ovf) begin
                    m_err = 1'b1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
                void'(q.pop_front());
            end
            if (in_hs) q.push_back(it);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && q.size() != 0; i++) cycle();
        chk("drain_empty", q.size(), 0);
    endtask

    // Present one item with the output ready, then check the result two cycles later.
    task automatic send_wait(input logic [31:0] t, input logic [31:0] p,
                             input logic [23:0] exp_lab, input logic exp_ovf);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        target    = t;
        pc        = p;
        cycle();
        in_valid = 1'b0;
        cycle();
        #1;
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lit_label", {8'd0, label}, {8'd0, exp_lab});
        chk("lit_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        if (!exp_ovf) chk("sext_eq_diff", {{8{label[23]}}, label}, t - p);
        cycle();
    endtask

    logic [31:0] bp_t [5] = '{32'h0000_0104, 32'h0000_0200, 32'h0080_0100, 32'h0000_0000, 32'hFFFF_FF00};
    int k;
    int off;

    initial begin
        rst = 1'b1; in_valid = 1'b0; target = 32'd0; pc = 32'd0;
        out_ready = 1'b1; clr_err = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_label", {8'd0, label}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", {24'd0, ovf_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send_wait(32'h0000_1000, 32'h0000_0F00, 24'h000100, 1'b0);
        send_wait(32'h0000_0000, 32'h0000_0010, 24'hFFFFF0, 1'b0);
        send_wait(32'h007F_FFFF, 32'h0000_0000, 24'h7FFFFF, 1'b0);
        send_wait(32'hFF80_0000, 32'h0000_0000, 24'h800000, 1'b0);
        send_wait(32'h0080_0000, 32'h0000_0000, 24'h800000, 1'b1);
        send_wait(32'hFF7F_FFFF, 32'h0000_0000, 24'h7FFFFF, 1'b1);
        chk("bnd_err", {31'd0, err}, 32'd1);
        chk("bnd_cnt", {24'd0, ovf_cnt}, 32'd2);

        // Backpressure: five items against a stalled consumer.
        out_ready = 1'b0;
        pc = 32'h0000_0100;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            target = bp_t[k];
            cycle();
            if (last_in_hs) k++;
        end
        chk("bp_accepts", k, 2);
        #1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 12 && k < 5; c++) begin
            in_valid = 1'b1;
            target = bp_t[k];
            cycle();
            if (last_in_hs) k++;
        end
        chk("bp_all_accepted", k, 5);
        drain();

        // Saturation and clear.
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        in_valid = 1'b1; target = 32'h4000_0000; pc = 32'h0000_0000; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        drain();
        chk("sat_cnt", {24'd0, ovf_cnt}, 32'd255);
        chk("sat_err", {31'd0, err}, 32'd1);
        in_valid = 1'b1; target = 32'h8000_0000;
        cycle();
        in_valid = 1'b0;
        cycle();
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        chk("clr_coinc_err", {31'd0, err}, 32'd1);
        chk("clr_coinc_cnt", {24'd0, ovf_cnt}, 32'd1);

        // Reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1; target = 32'h0000_0040; pc = 32'h0000_0000;
        for (int i = 0; i < 3; i++) cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_cnt", {24'd0, ovf_cnt}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_err   = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            pc        = $urandom;
            case ($urandom_range(0, 5))
                0: off = 8388607;
                1: off = 8388608;
                2: off = -8388608;
                3: off = -8388609;
                4: off = $urandom;
                default: off = $signed($urandom_range(0, 65535)) - 32768;
            endcase
            target = pc + off;
            cycle();
        end
        rst = 1'b0; clr_err = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/label_encoder.md
# label_encoder

Converts 32-bit absolute branch/jump target addresses into 24-bit PC-relative labels for the instruction-image loader path. It is the inverse of the branch datapath's 24-to-32-bit label sign extension. When no overflow is flagged, sign-extending the emitted label must reproduce the byte offset exactly. The block is a 2-stage valid/ready pipeline with per-item range checking, a sticky error flag and a saturating overflow counter.

## Interface
- `WORD_W`, 32, address/offset width
- `LABEL_W`, 24, label width (signed)
- `CNT_W`, 8, overflow counter width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset is synchronous and active-high
- `in_valid`  in  1  target/pc pair presented
- `in_ready`  out  1  block accepts pair this cycle
- `target`  in  WORD_W  absolute target address
- `pc`  in  WORD_W  address of the branch instruction
- `out_valid`  out  1  label result presented
- `out_ready`  in  1  consumer accepts result
- `label`  out  LABEL_W  encoded offset, diff[23:0]
- `ovf`  out  1  offset does not fit in signed LABEL_W
- `err`  out  1  sticky: any overflowed result handed off since reset/clear
- `ovf_cnt`  out  CNT_W  count of overflowed handoffs, saturating
- `clr_err`  in  1  synchronous clear of `err` and `ovf_cnt`

## Operation
- diff = target − pc, modulo 2^32 (two's-complement wrap, no carry out)
- ovf = NOT (diff[31:23] all 0 OR all 1); label = diff[23:0] regardless of ovf
- Stage 1 (S1) registers diff and a valid bit; stage 2 (S2) registers label, ovf and a valid bit
- adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready
- S2 loads from S1 when adv2. s2_valid ← s1_valid when adv2, else holds
- S1 loads on adv1. s1_valid ← in_valid when adv1, else holds
- Stalled stages hold data bit-stable; out_valid never drops without a handshake
- Counter/flag update per cycle, in this order:
  - clr_err → err=0, cnt=0
  - then, if the output handshake has ovf=1: err=1 and cnt+1, saturating at 2^CNT_W−1
- Simultaneous clr_err and an overflowed handshake → err=1, ovf_cnt=1
- Reset: s1_valid=s2_valid=0, label=0, ovf=0, err=0, ovf_cnt=0
  - out_valid=0 in the cycle after rst is sampled
  - in_ready=1 during and after reset
- Reset mid-stream discards all in-flight items; none are emitted afterwards

## Timing
- Latency: input handshake in cycle N → out_valid with result in cycle N+2, if unstalled
- Throughput: 1 item/cycle with out_ready held high
- in_ready depends combinationally on out_ready (one AND/OR level); no other combinational in→out paths
- Backpressure: with out_ready low, accepts exactly 2 items, then in_ready=0 until a handoff
- err/ovf_cnt reflect a handoff in the cycle after it

## Structure
- Shared package `kgp_risc_pkg` holds:
  - `WORD_W`, `LABEL_W`
  - `label_t` (logic [LABEL_W-1:0])
  - `word_t`
  - the shared function for the label fit check, so the encoder and the sign-extension side agree
- One combinational sub-module `label_range_check`: diff in → label, ovf out
- Pipeline, handshake and counter logic live in the top

## Test plan
- target=0x00001000, pc=0x00000F00 → label=0x000100, ovf=0, after exactly 2 cycles
- target=0x00000000, pc=0x00000010 → diff 0xFFFFFFF0, label=0xFFFFF0, ovf=0; sign-extension of label equals diff
- Boundaries: diff 0x007FFFFF and 0xFF800000 → ovf=0; diff 0x00800000 → label=0x800000, ovf=1; diff 0xFF7FFFFF → ovf=1, err=1, ovf_cnt=2
- Backpressure: stream 5 items, out_ready low 4 cycles → in_ready low after 2 accepts; all 5 emitted in order, unchanged while stalled
- Saturation/clear: 300 overflowed handoffs → ovf_cnt=255; clr_err coincident with an overflowed handoff → err=1, ovf_cnt=1
- rst asserted with both stages full → next cycle out_valid=0, ovf_cnt=0, err=0; stale items never appear
